id_ex_stage: RTL and testbench

- ID/EX pipeline register with operand forwarding and load-use hazard detection.
- Captures decoded operands and control from the decode stage.
- Forwards from EX/MEM and MEM/WB, and directly drives the 32-bit ALU's a, b and ALU_ctl inputs.
- Also produces the store-data operand and the load-use stall request for IF/ID.

---
 rtl/id_ex_stage.sv | 144 ++++++++++++++
 tb/tb_id_ex_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB forwarding and load-use detection.
// Optional stall-cycle counter output enabled by ID_EX_STALL_CNT_EN.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rt,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [3:0]            id_alu_ctl,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_data,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_a,
    output logic [DATA_W-1:0]     ex_b,
    output logic [3:0]            ex_alu_ctl,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  load_use_stall
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    logic                  valid_q;
    logic [REG_ADDR_W-1:0] rs_q;
    logic [REG_ADDR_W-1:0] rt_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]     rs_data_q;
    logic [DATA_W-1:0]     rt_data_q;
    logic [DATA_W-1:0]     imm_q;
    logic [3:0]            alu_ctl_q;
    logic                  alu_src_q;
    logic                  reg_write_q;
    logic                  mem_read_q;

    logic [DATA_W-1:0]     fwd_rs;
    logic [DATA_W-1:0]     fwd_rt;
    logic [DATA_W-1:0]     cap_rs;
    logic [DATA_W-1:0]     cap_rt;

    // EX/MEM is younger than MEM/WB, so it wins when both match.
    always_comb begin
        fwd_rs = rs_data_q;
        if (rs_q != '0 && exmem_reg_write && exmem_rd == rs_q)
            fwd_rs = exmem_result;
        else if (rs_q != '0 && memwb_reg_write && memwb_rd == rs_q)
            fwd_rs = memwb_data;
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (rt_q != '0 && exmem_reg_write && exmem_rd == rt_q)
            fwd_rt = exmem_result;
        else if (rt_q != '0 && memwb_reg_write && memwb_rd == rt_q)
            fwd_rt = memwb_data;
    end

    // Register file write and read can collide in the same cycle.
    always_comb begin
        cap_rs = id_rs_data;
        cap_rt = id_rt_data;
        if (id_rs != '0 && memwb_reg_write && memwb_rd == id_rs)
            cap_rs = memwb_data;
        if (id_rt != '0 && memwb_reg_write && memwb_rd == id_rt)
            cap_rt = memwb_data;
    end

    assign load_use_stall = valid_q & mem_read_q & (rd_q != '0) & id_valid &
                            ((rd_q == id_rs) | (id_uses_rt & (rd_q == id_rt)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q     <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            alu_ctl_q   <= '0;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (stall) begin
            rs_data_q <= fwd_rs;
            rt_data_q <= fwd_rt;
        end else if (load_use_stall) begin
            valid_q <= 1'b0;
        end else begin
            valid_q     <= id_valid;
            rs_q        <= id_rs;
            rt_q        <= id_rt;
            rd_q        <= id_rd;
            rs_data_q   <= cap_rs;
            rt_data_q   <= cap_rt;
            imm_q       <= id_imm;
            alu_ctl_q   <= id_alu_ctl;
            alu_src_q   <= id_alu_src;
            reg_write_q <= id_reg_write;
            mem_read_q  <= id_mem_read;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cycles <= '0;
        else if ((load_use_stall | stall) & ~flush)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

    assign ex_valid      = valid_q;
    assign ex_a          = fwd_rs;
    assign ex_b          = alu_src_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_alu_ctl    = alu_ctl_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = valid_q & reg_write_q;
    assign ex_mem_read   = valid_q & mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized run against a model.
module tb_id_ex_stage;

    logic        clk;
    logic        rstn;
    logic        stall, flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [3:0]  id_alu_ctl;
    logic        id_alu_src, id_reg_write, id_mem_read;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        ex_valid;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_alu_ctl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, load_use_stall;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    id_ex_stage dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alu_ctl(id_alu_ctl),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .exmem_reg_write(exmem_reg_write),
        .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_data(memwb_data), .ex_valid(ex_valid), .ex_a(ex_a),
        .ex_b(ex_b), .ex_alu_ctl(ex_alu_ctl), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .load_use_stall(load_use_stall)
`ifdef ID_EX_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction currently sitting in EX, as the model sees it
    typedef struct packed {
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [3:0]  ctl;
        logic        src, rw, mr;
    } ex_t;

    ex_t         m;
    logic [31:0] cnt_m;

    function automatic logic [31:0] resolve(input logic [4:0] idx,
                                            input logic [31:0] stored);
        if (idx == 0) return stored;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_data;
        return stored;
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] idx,
                                            input logic [31:0] rf);
        if (idx != 0 && memwb_reg_write && memwb_rd == idx) return memwb_data;
        return rf;
    endfunction

    function automatic logic hazard();
        if (!(m.v && m.mr && m.rd != 0 && id_valid)) return 1'b0;
        return (m.rd == id_rs) || (id_uses_rt && m.rd == id_rt);
    endfunction

    task automatic clr_inputs();
        stall = 0; flush = 0; id_valid = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alu_ctl = 0;
        id_alu_src = 0; id_reg_write = 0; id_mem_read = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clr_inputs();
        rstn = 0;
        tick();
        rstn = 1;
        #1;
    endtask

    task automatic test_reset();
        clr_inputs();
        rstn = 0;
        #2;
        total_cnt++;
        if (ex_valid !== 0 || ex_a !== 0 || ex_b !== 0 || ex_store_data !== 0)
            $display("FAIL reset_init valid=%b a=%h b=%h sd=%h required 0",
                     ex_valid, ex_a, ex_b, ex_store_data);
        else pass_cnt++;
        tick();
        rstn = 1;
        id_valid = 1; id_rd = 4; id_alu_ctl = 5; id_reg_write = 1;
        id_mem_read = 1; id_rs = 2; id_rs_data = 32'h1234;
        tick();
        total_cnt++;
        if (ex_valid !== 1 || ex_reg_write !== 1 || ex_a !== 32'h1234)
            $display("FAIL reset_load valid=%b rw=%b a=%h required 1 1 1234",
                     ex_valid, ex_reg_write, ex_a);
        else pass_cnt++;
        #1 rstn = 0;
        #1;
        total_cnt++;
        if (ex_valid !== 0 || ex_reg_write !== 0 || ex_mem_read !== 0 ||
            ex_alu_ctl !== 0 || ex_rd !== 0 || ex_a !== 0)
            $display("FAIL reset_async valid=%b rw=%b mr=%b ctl=%h rd=%h a=%h required 0",
                     ex_valid, ex_reg_write, ex_mem_read, ex_alu_ctl, ex_rd, ex_a);
        else pass_cnt++;
        #1 rstn = 1;
        id_valid = 0;
        tick();
        tick();
        total_cnt++;
        if (ex_valid !== 0)
            $display("FAIL reset_idle ex_valid=%b required 0", ex_valid);
        else pass_cnt++;
    endtask

    task automatic test_fwd_priority();
        apply_reset();
        id_valid = 1; id_rs = 3; id_rs_data = 32'h99;
        tick();
        id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 3; memwb_data = 32'h22;
        #1;
        total_cnt++;
        if (ex_a !== 32'h11) $display("FAIL fwd_exmem ex_a=%h required 11", ex_a);
        else pass_cnt++;
        exmem_reg_write = 0;
        #1;
        total_cnt++;
        if (ex_a !== 32'h22) $display("FAIL fwd_memwb ex_a=%h required 22", ex_a);
        else pass_cnt++;
        memwb_reg_write = 0;
        #1;
        total_cnt++;
        if (ex_a !== 32'h99) $display("FAIL fwd_none ex_a=%h required 99", ex_a);
        else pass_cnt++;
    endtask

    task automatic test_wb_bypass();
        apply_reset();
        id_valid = 1; id_rs = 10; id_rs_data = 32'h1;
        memwb_reg_write = 1; memwb_rd = 10; memwb_data = 32'h77;
        tick();
        memwb_reg_write = 0;
        #1;
        total_cnt++;
        if (ex_a !== 32'h77) $display("FAIL wb_bypass ex_a=%h required 77", ex_a);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        apply_reset();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5;
        tick();
        id_mem_read = 0; id_rd = 6;
        id_rs = 1; id_rt = 5; id_uses_rt = 1;
        #1;
        total_cnt++;
        if (load_use_stall !== 1)
            $display("FAIL lu_rt stall=%b required 1", load_use_stall);
        else pass_cnt++;
        id_uses_rt = 0; id_rs = 2;
        #1;
        total_cnt++;
        if (load_use_stall !== 0)
            $display("FAIL lu_norel stall=%b required 0", load_use_stall);
        else pass_cnt++;
        id_uses_rt = 1;
        tick();
        total_cnt++;
        if (ex_valid !== 0 || ex_mem_read !== 0 || load_use_stall !== 0)
            $display("FAIL lu_bubble valid=%b mr=%b stall=%b required 0 0 0",
                     ex_valid, ex_mem_read, load_use_stall);
        else pass_cnt++;
    endtask

    task automatic test_stall_hold();
        apply_reset();
        memwb_reg_write = 1; memwb_rd = 8; memwb_data = 32'h0;
        id_valid = 1; id_rs = 7; id_rs_data = 32'h01;
        tick();
        id_valid = 0;
        memwb_rd = 7; memwb_data = 32'h55;
        #1;
        total_cnt++;
        if (ex_a !== 32'h55) $display("FAIL hold_pre ex_a=%h required 55", ex_a);
        else pass_cnt++;
        stall = 1;
        tick();
        stall = 0;
        memwb_rd = 9; memwb_data = 32'h66;
        #1;
        total_cnt++;
        if (ex_a !== 32'h55 || ex_valid !== 1)
            $display("FAIL hold_post ex_a=%h valid=%b required 55 1", ex_a, ex_valid);
        else pass_cnt++;
    endtask

    task automatic test_flush_stall();
        apply_reset();
        id_valid = 1; id_reg_write = 1; id_rd = 6;
        tick();
        total_cnt++;
        if (ex_reg_write !== 1) $display("FAIL fl_pre rw=%b required 1", ex_reg_write);
        else pass_cnt++;
        flush = 1; stall = 1;
        tick();
        flush = 0; stall = 0; id_valid = 0;
        #1;
        total_cnt++;
        if (ex_valid !== 0 || ex_reg_write !== 0)
            $display("FAIL fl_stall valid=%b rw=%b required 0 0", ex_valid, ex_reg_write);
        else pass_cnt++;
    endtask

    task automatic test_imm_store();
        apply_reset();
        id_valid = 1; id_rt = 4; id_rt_data = 32'h1234;
        id_alu_src = 1; id_imm = 32'hFFFFFFFC;
        tick();
        id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'hABCD;
        #1;
        total_cnt++;
        if (ex_b !== 32'hFFFFFFFC || ex_store_data !== 32'hABCD)
            $display("FAIL imm_store b=%h sd=%h required fffffffc abcd",
                     ex_b, ex_store_data);
        else pass_cnt++;
        exmem_reg_write = 0;
        id_valid = 1; id_rs = 0; id_rt = 0; id_rs_data = 0; id_rt_data = 0;
        id_alu_src = 0;
        tick();
        id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hDEAD;
        memwb_reg_write = 1; memwb_rd = 0; memwb_data = 32'hBEEF;
        #1;
        total_cnt++;
        if (ex_a !== 0 || ex_b !== 0 || ex_store_data !== 0)
            $display("FAIL r0_nofwd a=%h b=%h sd=%h required 0", ex_a, ex_b, ex_store_data);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic hz;
        apply_reset();
        m = '0;
        cnt_m = 0;
        for (int i = 0; i < 500; i++) begin
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 5) == 0);
            id_valid = 1'($urandom_range(0, 1));
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
            id_alu_ctl = 4'($urandom_range(0, 15));
            id_alu_src = 1'($urandom_range(0, 1));
            id_reg_write = 1'($urandom_range(0, 1));
            id_mem_read = 1'($urandom_range(0, 1));
            exmem_reg_write = 1'($urandom_range(0, 1));
            exmem_rd = 5'($urandom_range(0, 3));
            exmem_result = $urandom;
            memwb_reg_write = 1'($urandom_range(0, 1));
            memwb_rd = 5'($urandom_range(0, 3));
            memwb_data = $urandom;
            #1;
            hz = hazard();
            total_cnt++;
            if (ex_valid !== m.v || ex_a !== resolve(m.rs, m.rsd) ||
                ex_b !== (m.src ? m.imm : resolve(m.rt, m.rtd)) ||
                ex_store_data !== resolve(m.rt, m.rtd) ||
                ex_alu_ctl !== m.ctl || ex_rd !== m.rd ||
                ex_reg_write !== (m.v & m.rw) || ex_mem_read !== (m.v & m.mr) ||
                load_use_stall !== hz)
                $display("FAIL rand_%0d v=%b a=%h b=%h sd=%h ctl=%h rd=%h rw=%b mr=%b lu=%b required v=%b a=%h b=%h sd=%h ctl=%h rd=%h lu=%b",
                         i, ex_valid, ex_a, ex_b, ex_store_data, ex_alu_ctl,
                         ex_rd, ex_reg_write, ex_mem_read, load_use_stall,
                         m.v, resolve(m.rs, m.rsd),
                         m.src ? m.imm : resolve(m.rt, m.rtd),
                         resolve(m.rt, m.rtd), m.ctl, m.rd, hz);
            else pass_cnt++;
`ifdef ID_EX_STALL_CNT_EN
            total_cnt++;
            if (stall_cycles !== cnt_m)
                $display("FAIL rand_cnt_%0d cnt=%0d required %0d", i, stall_cycles, cnt_m);
            else pass_cnt++;
`endif
            if ((hz || stall) && !flush) cnt_m = cnt_m + 1;
            if (flush) begin
                m.v = 0;
            end else if (stall) begin
                m.rsd = resolve(m.rs, m.rsd);
                m.rtd = resolve(m.rt, m.rtd);
            end else if (hz) begin
                m.v = 0;
            end else begin
                m.v = id_valid; m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
                m.rsd = rf_read(id_rs, id_rs_data);
                m.rtd = rf_read(id_rt, id_rt_data);
                m.imm = id_imm; m.ctl = id_alu_ctl; m.src = id_alu_src;
                m.rw = id_reg_write; m.mr = id_mem_read;
            end
            tick();
        end
    endtask

    initial begin
        rstn = 0;
        clr_inputs();
        #1;
        test_reset();
        test_fwd_priority();
        test_wb_bypass();
        test_load_use();
        test_stall_hold();
        test_flush_stall();
        test_imm_store();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
